// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC accumulate stage.
// Product width is common with the upstream 8x8 multiplier.
package mac_pkg;

    localparam int ACC_W_DEF = 20;
    localparam int LEN_W_DEF = 4;
    localparam int PROD_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/mac_sat_add.sv
// Combinational ACC_W-bit accumulate add with carry-out.
// MAC_ACC_SATURATE_EN defined: clamp to all-ones on carry; otherwise wrap.
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide_sum;

    always_comb begin
        wide_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
        carry    = wide_sum[ACC_W];
`ifdef MAC_ACC_SATURATE_EN
        sum      = carry ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
        sum      = wide_sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates a programmed number of 16-bit products into an ACC_W-bit sum.
// Overflow behaviour is selected by MAC_ACC_SATURATE_EN (see mac_sat_add).
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow,
    output logic              busy
);

    // One extra bit so a len of 0 can hold the full 2^LEN_W term count.
    localparam logic [LEN_W:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] CNT_FULL = {1'b1, {LEN_W{1'b0}}};

    state_e           state_q, state_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_carry;

    mac_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc    (acc_q),
        .addend (product),
        .sum    (add_sum),
        .carry  (add_carry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = (len == '0) ? CNT_FULL : {1'b0, len};
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_carry;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Status outputs are registered copies of the next-state decode.
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: a 20-bit and an 18-bit instance share
// one stimulus stream and are compared against a sum-of-terms reference model.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [15:0] product = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, ovf_a, busy_a;
    logic [19:0] acc_a;
    logic        in_ready_b, out_valid_b, ovf_b, busy_b;
    logic [17:0] acc_b;

    int tests = 0;
    int fails = 0;
    int unsigned pq[$];

    always #5 clk = ~clk;

    mac_accumulator #(.ACC_W(20), .LEN_W(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_a), .product(product),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .acc_out(acc_a), .overflow(ovf_a), .busy(busy_a)
    );

    mac_accumulator #(.ACC_W(18), .LEN_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready_b), .product(product),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .acc_out(acc_b), .overflow(ovf_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: the true (unbounded) sum decides everything. It overflows a
    // W-bit accumulator exactly when it reaches 2^W; the sum is monotone, so
    // saturation yields all-ones and wrapping yields the sum modulo 2^W.
    function automatic logic [63:0] model_acc(input int w, input longint unsigned total);
        longint unsigned lim;
        lim = 64'd1 << w;
        if (total < lim) return total;
`ifdef MAC_ACC_SATURATE_EN
        return lim - 1;
`else
        return total % lim;
`endif
    endfunction

    function automatic logic [63:0] model_ovf(input int w, input longint unsigned total);
        return {63'd0, (total >= (64'd1 << w))};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".in_ready"},  {63'd0, in_ready_a} | {63'd0, in_ready_b}, 64'd0);
        check({tag, ".out_valid"}, {63'd0, out_valid_a} | {63'd0, out_valid_b}, 64'd0);
        check({tag, ".busy"},      {63'd0, busy_a} | {63'd0, busy_b}, 64'd0);
        check({tag, ".acc_a"},     {44'd0, acc_a}, 64'd0);
        check({tag, ".acc_b"},     {46'd0, acc_b}, 64'd0);
        check({tag, ".ovf"},       {63'd0, ovf_a} | {63'd0, ovf_b}, 64'd0);
    endtask

    // Runs the terms in pq through both instances. Called at posedge+1.
    task automatic run(input string tag, input int gap_max, input int stall,
                       input bit pulse_start, input bit junk_with_start);
        int n;
        longint unsigned total;
        logic [63:0] ea, eb, oa, ob;
        n = pq.size();
        total = 0;
        foreach (pq[i]) total += pq[i];
        ea = model_acc(20, total);  oa = model_ovf(20, total);
        eb = model_acc(18, total);  ob = model_ovf(18, total);

        start = 1'b1;
        len   = (n == 16) ? 4'd0 : 4'(n);
        in_valid = junk_with_start;
        product  = 16'hFFFF;
        step();
        start = 1'b0;
        in_valid = 1'b0;
        check({tag, ".busy_after_start"}, {62'd0, busy_a, busy_b}, 64'd3);
        check({tag, ".in_ready_after_start"}, {62'd0, in_ready_a, in_ready_b}, 64'd3);
        check({tag, ".acc_cleared"}, {44'd0, acc_a}, 64'd0);

        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                product  = 16'($urandom);
                step();
                check({tag, ".in_ready_gap"}, {62'd0, in_ready_a, in_ready_b}, 64'd3);
            end
            check({tag, ".in_ready_beat"}, {62'd0, in_ready_a, in_ready_b}, 64'd3);
            in_valid = 1'b1;
            product  = 16'(pq[i]);
            step();
        end
        in_valid = 1'b0;

        check({tag, ".out_valid"}, {62'd0, out_valid_a, out_valid_b}, 64'd3);
        check({tag, ".acc_a"}, {44'd0, acc_a}, ea);
        check({tag, ".ovf_a"}, {63'd0, ovf_a}, oa);
        check({tag, ".acc_b"}, {46'd0, acc_b}, eb);
        check({tag, ".ovf_b"}, {63'd0, ovf_b}, ob);
        check({tag, ".in_ready_done"}, {62'd0, in_ready_a, in_ready_b}, 64'd0);

        for (int s = 0; s < stall; s++) begin
            start = pulse_start && (s == 1);
            len   = 4'd1;
            step();
            check({tag, ".stall_valid"}, {62'd0, out_valid_a, out_valid_b}, 64'd3);
            check({tag, ".stall_acc_a"}, {44'd0, acc_a}, ea);
            check({tag, ".stall_acc_b"}, {46'd0, acc_b}, eb);
            check({tag, ".stall_in_ready"}, {62'd0, in_ready_a, in_ready_b}, 64'd0);
        end
        start = 1'b0;

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".released_valid"}, {62'd0, out_valid_a, out_valid_b}, 64'd0);
        check({tag, ".released_busy"}, {62'd0, busy_a, busy_b}, 64'd0);
        $display("[TB] %s: %0d terms sum=%0d acc20=%0d ovf20=%0d acc18=%0d ovf18=%0d",
                 tag, n, total, ea, oa, eb, ob);
    endtask

    initial begin
        #2;
        check_idle_outputs("reset");
        step();
        rst = 1'b0;
        step();
        check_idle_outputs("post_reset");

        // Basic sum, with a product offered alongside start that must be dropped.
        pq = '{100, 200, 300};
        run("basic", 0, 0, 1'b0, 1'b1);

        // Back-to-back run straight after the handshake.
        pq = '{65025, 65025, 65025, 65025, 65025};
        run("overflow", 0, 0, 1'b0, 1'b0);

        // len=0 means 16 terms; random stalls between beats.
        pq.delete();
        for (int i = 0; i < 16; i++) pq.push_back(65535);
        run("len0_stalls", 2, 0, 1'b0, 1'b0);

        // Output backpressure with an ignored start pulse.
        pq = '{1234, 4321};
        run("backpressure", 0, 5, 1'b1, 1'b0);

        // Reset mid-run after 2 of 4 beats.
        start = 1'b1;
        len   = 4'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            product  = 16'd5000;
            step();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        step();
        check_idle_outputs("after_midrun_reset");
        pq = '{7};
        run("after_reset", 0, 0, 1'b0, 1'b0);

        // Randomized runs using products of 8-bit operands.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = int'($urandom_range(1, 16));
            pq.delete();
            for (int i = 0; i < n; i++)
                pq.push_back($urandom_range(0, 255) * $urandom_range(0, 255));
            run($sformatf("random%0d", r), 1, int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
